// File: rtl/vga_pkg.sv
// Shared display constants and helpers for the frogger VGA path.
// Holds default 640x480 raster timing, position/counter widths, sprite colour
// selections and the sprite span hit test used by the renderers.
package vga_pkg;

    localparam int unsigned H_DISPLAY_DEF = 640;
    localparam int unsigned H_FRONT_DEF   = 16;
    localparam int unsigned H_SYNC_DEF    = 96;
    localparam int unsigned H_BACK_DEF    = 48;
    localparam int unsigned V_DISPLAY_DEF = 480;
    localparam int unsigned V_FRONT_DEF   = 10;
    localparam int unsigned V_SYNC_DEF    = 2;
    localparam int unsigned V_BACK_DEF    = 33;

    localparam int unsigned POS_W = 10;
    // Counters and hit tests run one bit wider than positions so x+size never wraps.
    localparam int unsigned CNT_W = 11;

    // Which channels are driven full-scale for a layer.
    typedef struct packed {
        logic r;
        logic g;
        logic b;
    } rgb_sel_t;

    localparam rgb_sel_t COLOR_BG   = '{r: 1'b0, g: 1'b0, b: 1'b0};
    localparam rgb_sel_t COLOR_FROG = '{r: 1'b0, g: 1'b1, b: 1'b0};
    localparam rgb_sel_t COLOR_CAR  = '{r: 1'b1, g: 1'b0, b: 1'b0};

    // True when p lies in [s, s+size).
    function automatic logic in_span(input logic [CNT_W-1:0] p,
                                     input logic [POS_W-1:0] s,
                                     input logic [CNT_W-1:0] size);
        logic [CNT_W-1:0] lo;
        lo = CNT_W'(s);
        return (p >= lo) && (p < lo + size);
    endfunction

endpackage

// File: rtl/vga_scene_controller_if.sv
// Game-logic <-> scene engine bundle.
// master: game logic (drives sprite positions/enables, observes video + collision)
// slave : scene controller (consumes positions, drives RGB, syncs, frame_start, collision)
interface vga_scene_controller_if
    import vga_pkg::*;
#(
    parameter int unsigned NUM_CARS   = 4,
    parameter int unsigned COLOR_BITS = 3
);
    logic [POS_W-1:0]          frog_x;
    logic [POS_W-1:0]          frog_y;
    logic [POS_W*NUM_CARS-1:0] car_x;
    logic [POS_W*NUM_CARS-1:0] car_y;
    logic [NUM_CARS-1:0]       car_en;
    logic [COLOR_BITS-1:0]     red;
    logic [COLOR_BITS-1:0]     green;
    logic [COLOR_BITS-1:0]     blue;
    logic                      hsync;
    logic                      vsync;
    logic                      frame_start;
    logic                      collision;

    modport master (
        output frog_x, frog_y, car_x, car_y, car_en,
        input  red, green, blue, hsync, vsync, frame_start, collision
    );

    modport slave (
        input  frog_x, frog_y, car_x, car_y, car_en,
        output red, green, blue, hsync, vsync, frame_start, collision
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Raster counter generator.
// Ports: clk_i/rst_i, h_cnt_o/v_cnt_o (registered counters), active_c_o,
// hsync_c_o/vsync_c_o (raw, active-high), frame_last_c_o (last cycle of frame).
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_DISPLAY = H_DISPLAY_DEF,
    parameter int unsigned H_FRONT   = H_FRONT_DEF,
    parameter int unsigned H_SYNC    = H_SYNC_DEF,
    parameter int unsigned H_BACK    = H_BACK_DEF,
    parameter int unsigned V_DISPLAY = V_DISPLAY_DEF,
    parameter int unsigned V_FRONT   = V_FRONT_DEF,
    parameter int unsigned V_SYNC    = V_SYNC_DEF,
    parameter int unsigned V_BACK    = V_BACK_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    output logic [CNT_W-1:0] h_cnt_o,
    output logic [CNT_W-1:0] v_cnt_o,
    output logic             active_c_o,
    output logic             hsync_c_o,
    output logic             vsync_c_o,
    output logic             frame_last_c_o
);

    localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    logic [CNT_W-1:0] h_q, h_d;
    logic [CNT_W-1:0] v_q, v_d;
    logic             h_last, v_last;

    assign h_last = (h_q == CNT_W'(H_TOTAL - 1));
    assign v_last = (v_q == CNT_W'(V_TOTAL - 1));

    // Counter advance: v steps when h wraps.
    always_comb begin
        h_d = h_q + CNT_W'(1);
        v_d = v_q;
        if (h_last) begin
            h_d = '0;
            v_d = v_last ? '0 : v_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    assign h_cnt_o        = h_q;
    assign v_cnt_o        = v_q;
    assign active_c_o     = (h_q < CNT_W'(H_DISPLAY)) && (v_q < CNT_W'(V_DISPLAY));
    assign hsync_c_o      = (h_q >= CNT_W'(H_DISPLAY + H_FRONT)) &&
                            (h_q <  CNT_W'(H_DISPLAY + H_FRONT + H_SYNC));
    assign vsync_c_o      = (v_q >= CNT_W'(V_DISPLAY + V_FRONT)) &&
                            (v_q <  CNT_W'(V_DISPLAY + V_FRONT + V_SYNC));
    assign frame_last_c_o = h_last && v_last;

endmodule

// File: rtl/vga_scene_controller.sv
// Frogger scene engine: raster timing, frog + car sprite rendering over a black
// background, frame-boundary double-buffered positions and a per-frame
// frog/car collision flag.
// Ports: clk, rst (async, active-high); bus (slave modport) carrying sprite
// positions/enables in and registered RGB, syncs, frame_start, collision out.
module vga_scene_controller
    import vga_pkg::*;
#(
    parameter int unsigned H_DISPLAY   = H_DISPLAY_DEF,
    parameter int unsigned H_FRONT     = H_FRONT_DEF,
    parameter int unsigned H_SYNC      = H_SYNC_DEF,
    parameter int unsigned H_BACK      = H_BACK_DEF,
    parameter int unsigned V_DISPLAY   = V_DISPLAY_DEF,
    parameter int unsigned V_FRONT     = V_FRONT_DEF,
    parameter int unsigned V_SYNC      = V_SYNC_DEF,
    parameter int unsigned V_BACK      = V_BACK_DEF,
    parameter bit          SYNC_POL    = 1'b1,
    parameter int unsigned NUM_CARS    = 4,
    parameter int unsigned SPRITE_SIZE = 32,
    parameter int unsigned COLOR_BITS  = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    vga_scene_controller_if.slave   bus
);

    localparam logic [CNT_W-1:0] SPR_W = CNT_W'(SPRITE_SIZE);

    logic [CNT_W-1:0] h_cnt, v_cnt;
    logic             active_c, hsync_c, vsync_c, frame_last_c;

    vga_timing_gen #(
        .H_DISPLAY (H_DISPLAY), .H_FRONT (H_FRONT), .H_SYNC (H_SYNC), .H_BACK (H_BACK),
        .V_DISPLAY (V_DISPLAY), .V_FRONT (V_FRONT), .V_SYNC (V_SYNC), .V_BACK (V_BACK)
    ) u_timing (
        .clk_i          (clk),
        .rst_i          (rst),
        .h_cnt_o        (h_cnt),
        .v_cnt_o        (v_cnt),
        .active_c_o     (active_c),
        .hsync_c_o      (hsync_c),
        .vsync_c_o      (vsync_c),
        .frame_last_c_o (frame_last_c)
    );

    // Shadow copies of the game-side positions; only these are rendered.
    logic [POS_W-1:0]          frog_x_q, frog_y_q;
    logic [POS_W*NUM_CARS-1:0] car_x_q, car_y_q;
    logic [NUM_CARS-1:0]       car_en_q;

    logic                      frog_hit_c;
    logic [NUM_CARS-1:0]       car_hit_c;
    logic                      any_car_c;
    logic                      overlap_c;

    assign frog_hit_c = in_span(h_cnt, frog_x_q, SPR_W) && in_span(v_cnt, frog_y_q, SPR_W);

    for (genvar i = 0; i < NUM_CARS; i++) begin : g_car
        assign car_hit_c[i] = car_en_q[i] &&
                              in_span(h_cnt, car_x_q[POS_W*i +: POS_W], SPR_W) &&
                              in_span(v_cnt, car_y_q[POS_W*i +: POS_W], SPR_W);
    end

    assign any_car_c = |car_hit_c;
    assign overlap_c = active_c && frog_hit_c && any_car_c;

    // Output pipeline stage and collision accumulator.
    rgb_sel_t              sel_d;
    logic [COLOR_BITS-1:0] red_q, green_q, blue_q;
    logic                  hsync_q, vsync_q, frame_start_q, collision_q;
    logic                  acc_q, acc_d, collision_d;

    always_comb begin
        sel_d = COLOR_BG;
        if (active_c) begin
            if (any_car_c) begin
                sel_d = COLOR_CAR;
            end else if (frog_hit_c) begin
                sel_d = COLOR_FROG;
            end
        end
    end

    // A hit on the closing cycle still belongs to the frame being closed.
    always_comb begin
        acc_d       = acc_q | overlap_c;
        collision_d = collision_q;
        if (frame_last_c) begin
            collision_d = acc_q | overlap_c;
            acc_d       = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frog_x_q      <= '0;
            frog_y_q      <= '0;
            car_x_q       <= '0;
            car_y_q       <= '0;
            car_en_q      <= '0;
            acc_q         <= 1'b0;
            collision_q   <= 1'b0;
            red_q         <= '0;
            green_q       <= '0;
            blue_q        <= '0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            frame_start_q <= 1'b0;
        end else begin
            if (frame_last_c) begin
                frog_x_q <= bus.frog_x;
                frog_y_q <= bus.frog_y;
                car_x_q  <= bus.car_x;
                car_y_q  <= bus.car_y;
                car_en_q <= bus.car_en;
            end
            acc_q         <= acc_d;
            collision_q   <= collision_d;
            red_q         <= {COLOR_BITS{sel_d.r}};
            green_q       <= {COLOR_BITS{sel_d.g}};
            blue_q        <= {COLOR_BITS{sel_d.b}};
            hsync_q       <= hsync_c ? SYNC_POL : ~SYNC_POL;
            vsync_q       <= vsync_c ? SYNC_POL : ~SYNC_POL;
            frame_start_q <= (h_cnt == '0) && (v_cnt == '0);
        end
    end

    assign bus.red         = red_q;
    assign bus.green       = green_q;
    assign bus.blue        = blue_q;
    assign bus.hsync       = hsync_q;
    assign bus.vsync       = vsync_q;
    assign bus.frame_start = frame_start_q;
    assign bus.collision   = collision_q;

endmodule

// File: tb/tb_vga_scene_controller.sv
// Randomized bench for vga_scene_controller on a reduced raster, compared
// cycle by cycle against a frame-level behavioural model.
module tb_vga_scene_controller;

    localparam int HD = 64, HF = 4, HS = 8, HB = 4;
    localparam int VD = 48, VF = 2, VS = 2, VB = 3;
    localparam int HT = HD + HF + HS + HB;
    localparam int VT = VD + VF + VS + VB;
    localparam int FT = HT * VT;
    localparam int NC = 4;
    localparam int SZ = 8;
    localparam int CB = 3;
    localparam bit POL = 1'b0;

    logic clk = 1'b0;
    logic rst = 1'b1;

    vga_scene_controller_if #(.NUM_CARS(NC), .COLOR_BITS(CB)) bus ();

    vga_scene_controller #(
        .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SYNC_POL(POL), .NUM_CARS(NC), .SPRITE_SIZE(SZ), .COLOR_BITS(CB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%0h expected=%0h", tag, $time, obs, exp);
        end
    endtask

    // Game-side positions currently driven.
    int in_fx, in_fy;
    int in_cx[NC], in_cy[NC];
    bit in_en[NC];

    // Model: positions latched for the frame being drawn, collision state.
    int sh_fx, sh_fy;
    int sh_cx[NC], sh_cy[NC];
    bit sh_en[NC];
    bit m_acc, m_col;
    int k;

    task automatic drive_inputs();
        bus.frog_x = 10'(in_fx);
        bus.frog_y = 10'(in_fy);
        for (int i = 0; i < NC; i++) begin
            bus.car_x[10*i +: 10] = 10'(in_cx[i]);
            bus.car_y[10*i +: 10] = 10'(in_cy[i]);
            bus.car_en[i]         = in_en[i];
        end
    endtask

    function automatic int rand_pos();
        if ($urandom_range(0, 9) == 0) return int'($urandom_range(0, 1023));
        return int'($urandom_range(0, 70));
    endfunction

    task automatic randomize_scene();
        in_fx = rand_pos();
        in_fy = rand_pos();
        for (int i = 0; i < NC; i++) begin
            in_cx[i] = rand_pos();
            in_cy[i] = rand_pos();
            in_en[i] = 1'($urandom_range(0, 1));
        end
        // Bias toward overlaps so the collision path is exercised.
        if ($urandom_range(0, 1) == 1) begin
            in_cx[0] = in_fx + int'($urandom_range(0, 2 * SZ)) - SZ;
            in_cy[0] = in_fy + int'($urandom_range(0, 2 * SZ)) - SZ;
            if (in_cx[0] < 0) in_cx[0] = 0;
            if (in_cy[0] < 0) in_cy[0] = 0;
            in_en[0] = 1'b1;
        end
        drive_inputs();
    endtask

    task automatic model_reset();
        k = 0;
        sh_fx = 0; sh_fy = 0;
        for (int i = 0; i < NC; i++) begin
            sh_cx[i] = 0; sh_cy[i] = 0; sh_en[i] = 1'b0;
        end
        m_acc = 1'b0;
        m_col = 1'b0;
    endtask

    function automatic bit inside_spr(int h, int v, int x, int y);
        return (h >= x) && (h < x + SZ) && (v >= y) && (v < y + SZ);
    endfunction

    // One output cycle: check pixel index k-1 against the model, then step inputs.
    task automatic step();
        int p, h, v;
        bit act, frog, car, hs_act, vs_act;
        logic [8:0] exp_rgb;
        @(negedge clk);
        k++;
        p = (k - 1) % FT;
        h = p % HT;
        v = p / HT;
        act  = (h < HD) && (v < VD);
        frog = inside_spr(h, v, sh_fx, sh_fy);
        car  = 1'b0;
        for (int i = 0; i < NC; i++)
            if (sh_en[i] && inside_spr(h, v, sh_cx[i], sh_cy[i])) car = 1'b1;
        exp_rgb = 9'd0;
        if (act && car)       exp_rgb = 9'b111_000_000;
        else if (act && frog) exp_rgb = 9'b000_111_000;
        hs_act = (h >= HD + HF) && (h < HD + HF + HS);
        vs_act = (v >= VD + VF) && (v < VD + VF + VS);
        if (act && frog && car) m_acc = 1'b1;
        if (p == FT - 1) begin
            m_col = m_acc;
            m_acc = 1'b0;
            sh_fx = in_fx; sh_fy = in_fy;
            for (int i = 0; i < NC; i++) begin
                sh_cx[i] = in_cx[i]; sh_cy[i] = in_cy[i]; sh_en[i] = in_en[i];
            end
        end
        chk("rgb", 32'({bus.red, bus.green, bus.blue}), 32'(exp_rgb));
        chk("sync", 32'({bus.hsync, bus.vsync}),
            32'({hs_act ? POL : ~POL, vs_act ? POL : ~POL}));
        chk("frame_start", 32'(bus.frame_start), 32'(p == 0));
        chk("collision", 32'(bus.collision), 32'(m_col));
        // New scene near frame start, plus occasional mid-frame changes.
        if ((p == 0 && $urandom_range(0, 3) != 0) || $urandom_range(0, 699) == 0)
            randomize_scene();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rgb"}, 32'({bus.red, bus.green, bus.blue}), 32'd0);
        chk({tag, "_sync"}, 32'({bus.hsync, bus.vsync}), 32'({~POL, ~POL}));
        chk({tag, "_fs"}, 32'(bus.frame_start), 32'd0);
        chk({tag, "_col"}, 32'(bus.collision), 32'd0);
    endtask

    initial begin
        in_fx = 0; in_fy = 0;
        for (int i = 0; i < NC; i++) begin
            in_cx[i] = 0; in_cy[i] = 0; in_en[i] = 1'b0;
        end
        drive_inputs();
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs("rst_init");
        randomize_scene();
        rst = 1'b0;

        repeat (7 * FT) step();

        // Asynchronous reset in the middle of a line.
        repeat (FT / 2 + 17) step();
        #2 rst = 1'b1;
        #1 check_reset_outputs("rst_async");
        repeat (3) begin
            @(negedge clk);
            check_reset_outputs("rst_hold");
        end
        model_reset();
        rst = 1'b0;

        repeat (6 * FT) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_scene_controller.md
# vga_scene_controller

Parametrised VGA scene engine for the frogger display path: generates raster timing from parameters and renders one frog sprite plus `NUM_CARS` car sprites over a background. All video outputs are registered, and sprite positions are double-buffered at frame boundaries to prevent tearing. A per-frame frog/car collision flag is produced for the game-logic FSM. It sits between the game-state logic (positions in) and the board VGA pins (RGB/sync out).

## Interface
- `H_DISPLAY`, 640, active pixels per line
- `H_FRONT`, 16, horizontal front porch
- `H_SYNC`, 96, horizontal sync width
- `H_BACK`, 48, horizontal back porch
- `V_DISPLAY`, 480, active lines per frame
- `V_FRONT`, 10, vertical front porch
- `V_SYNC`, 2, vertical sync width
- `V_BACK`, 33, vertical back porch
- `SYNC_POL`, 1, sync active level (1 = active-high, 0 = active-low)
- `NUM_CARS`, 4, number of car sprites (1..8)
- `SPRITE_SIZE`, 32, square side of frog and car sprites, in pixels
- `COLOR_BITS`, 3, bits per colour channel
- `clk  in  1`  pixel clock
- `rst  in  1`  asynchronous, active-high reset
- `frog_x, frog_y  in  10 each`  frog top-left position
- `car_x, car_y  in  10*NUM_CARS each`  flattened car top-left positions; car i occupies bits [10i+9:10i]
- `car_en  in  NUM_CARS`  per-car enable; disabled cars are neither drawn nor collided
- `red, green, blue  out  COLOR_BITS each`  registered pixel colour
- `hsync, vsync  out  1`  registered sync
- `frame_start  out  1`  one-cycle pulse on the first active pixel cycle of each frame
- `collision  out  1`  frog overlapped an enabled car during the previous frame

## Operation
- `H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK` and `V_TOTAL` are defined the same way. `h_cnt` counts 0..H_TOTAL-1; `v_cnt` increments when `h_cnt` wraps and itself wraps at V_TOTAL-1.
- The active region is `h_cnt < H_DISPLAY && v_cnt < V_DISPLAY`. Outside the active region, RGB is forced to 0.
- Sync is active when `h_cnt` is in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC), and likewise for vsync. The output level equals SYNC_POL when active and ~SYNC_POL otherwise.
- **Shadow registers:** frog/car positions and `car_en` are sampled into shadow registers only on the last cycle of the frame (h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1). Rendering uses shadow values only.
- **Hit test:** pixel (h,v) is inside a sprite at (x,y) when `x <= h < x+SPRITE_SIZE` and `y <= v < y+SPRITE_SIZE`. The comparison is evaluated at 11 bits, so `x+SPRITE_SIZE` never wraps. Sprites extending past the display edge are clipped and do not wrap.
- **Layering, lowest to highest:**
  - background: black
  - frog: green = all ones, other channels 0
  - cars: red = all ones, other channels 0
  - Cars are drawn over the frog. All cars share one colour, so their relative order is irrelevant.
- **Collision accumulator:** set on any active-region pixel that is inside both the frog and an enabled car. On the frame's last cycle, `collision` loads the accumulator value and the accumulator clears. If a hit occurs on that last cycle, it is counted in the frame being closed.

## Timing
- **Reset values:** `h_cnt`=`v_cnt`=0; shadows 0; `car_en` shadow 0; accumulator 0. Outputs: RGB 0, hsync=vsync=~SYNC_POL, frame_start 0, collision 0.
- **Latency:** exactly 1 cycle. Outputs at edge n+1 reflect counter state (h,v) at edge n, so RGB and sync stay mutually aligned.
- `frame_start` is high for the single output cycle corresponding to counter (0,0).
- A position change is visible from the next frame boundary only. Changes mid-frame have no effect on the current frame.
- **Mid-operation reset:** asynchronous return to reset values. The first frame after release starts at (0,0) and uses zeroed shadows, i.e. no cars are enabled.
- `collision` changes only on the frame's last cycle and is stable for a full frame.

## Structure
- **Shared package `vga_pkg`:** default 640x480 timing constants, `POS_W`=10, and colour constants (`COLOR_FROG`, `COLOR_CAR`, `COLOR_BG`).
- **Sub-module `vga_timing_gen`:** the counters, active flag, raw sync, and the frame-last strobe, reusable by other display blocks.
- The sprite compare loop over `NUM_CARS` is a generate loop inside `vga_scene_controller`.

## Test plan
- **Timing:** defaults, run 2 frames. Expect hsync period 800 clk with a 96-clk active pulse starting at h=656, vsync period 420000 clk with 2 lines active, and `frame_start` every 420000 clk.
- **Sprite render:** frog (100,100), car0 (300,200) enabled. Expect green at counter (100,100) → output one cycle later, black at (132,100), red at (300,200), black at (332,231).
- **Overlap/collision:** frog (50,50), car1 (60,60), then car1 moved to (400,400). Expect red at (70,70) and `collision`=1 for one frame after the overlap frame, then 0 the frame after the move.
- **Double buffering:** change car0_x at h=10, v=240. Expect the current frame unchanged and the new position from the next `frame_start`.
- **Edge clipping:** car2 at (630,470). Expect red only for h in 630..639 and v in 470..479, with no red at h=0..21.
- **Async reset and polarity:** assert `rst` mid-line with SYNC_POL=0. Expect immediately RGB=0, hsync=vsync=1, collision=0; after release, counters restart at (0,0) and cars stay hidden until the first boundary reload.
